// File: rtl/rv32i_pkg.sv
// Shared rv32i core types: hazard controller FSM state and scoreboard constants.
package rv32i_pkg;

  localparam int unsigned SB_CNTW  = 2;
  localparam int unsigned HC_FCNTW = 3;

  typedef enum logic [1:0] {
    HC_RUN   = 2'd0,
    HC_STALL = 2'd1,
    HC_FLUSH = 2'd2
  } hc_state_t;

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: saturating up/down count of in-flight writes to a register.
module sb_counter
  import rv32i_pkg::*;
#(
  parameter int unsigned CNTW = SB_CNTW
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic busy
);

  localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && cnt_q != CntMax) begin
      cnt_d = cnt_q + CNTW'(1);
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

  // Both cases mean the pipeline lost track of a write; the count holds at its limit.
  overflow_chk : assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && cnt_q == CntMax));
  underflow_chk : assert property (@(posedge clk) disable iff (rst)
    !(dec && !inc && cnt_q == '0));

endmodule

// File: rtl/hazard_ctrl.sv
// RAW-stall / branch-flush controller with per-register write scoreboard.
// Define HAZARD_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned ADW       = 5,
  parameter int unsigned NREG      = 32,
  parameter int unsigned CNTW      = SB_CNTW,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validD,
  input  logic [ADW-1:0]  rs1D,
  input  logic [ADW-1:0]  rs2D,
  input  logic            use_rs1D,
  input  logic            use_rs2D,
  input  logic [ADW-1:0]  RdD,
  input  logic            regwriteD,
  input  logic [ADW-1:0]  RdW,
  input  logic            regwriteW,
  input  logic            branch_takenE,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic            flushE,
  output logic [NREG-1:0] busy_regs,
  output logic [1:0]      state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  localparam logic [HC_FCNTW-1:0] FlushLoad  = HC_FCNTW'(FLUSH_CYC - 1);
  localparam bit                  MultiFlush = (FLUSH_CYC > 1);

  hc_state_t           state_q, state_d;
  logic [HC_FCNTW-1:0] fcnt_q, fcnt_d;
  logic [NREG-1:1]     busy_hi;
  logic                hazard, in_flush, issue, retire;

  // x0 has no counter and is never busy.
  assign busy_regs = {busy_hi, 1'b0};
  assign in_flush  = (state_q == HC_FLUSH);

  assign hazard = validD && ((use_rs1D && rs1D != '0 && busy_regs[rs1D]) ||
                             (use_rs2D && rs2D != '0 && busy_regs[rs2D]));

  assign issue  = !rst && validD && regwriteD && RdD != '0 && !hazard && !in_flush &&
                  !branch_takenE;
  assign retire = !rst && regwriteW && RdW != '0;

  for (genvar i = 1; i < NREG; i++) begin : g_sb
    sb_counter #(
      .CNTW(CNTW)
    ) u_sb (
      .clk (clk),
      .rst (rst),
      .inc (issue && (RdD == ADW'(i))),
      .dec (retire && (RdW == ADW'(i))),
      .busy(busy_hi[i])
    );
  end

  // Priority: taken branch, then flush window, then hazard stall.
  always_comb begin
    flushD = 1'b0;
    flushE = 1'b0;
    stallD = 1'b0;
    stallF = 1'b0;
    if (!rst) begin
      flushD = branch_takenE || in_flush;
      flushE = branch_takenE || hazard;
      stallD = hazard && !branch_takenE && !in_flush;
      stallF = stallD;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      HC_RUN, HC_STALL: begin
        if (branch_takenE) begin
          if (MultiFlush) begin
            state_d = HC_FLUSH;
            fcnt_d  = FlushLoad;
          end else begin
            state_d = HC_RUN;
          end
        end else begin
          state_d = hazard ? HC_STALL : HC_RUN;
        end
      end
      HC_FLUSH: begin
        if (branch_takenE) begin
          fcnt_d = FlushLoad;
        end else if (fcnt_q <= HC_FCNTW'(1)) begin
          state_d = HC_RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - HC_FCNTW'(1);
        end
      end
      default: begin
        state_d = HC_RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HC_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stallD) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_takenE) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a count-per-register model.
module tb_hazard_ctrl;
  import rv32i_pkg::*;

  localparam int unsigned FLUSH_CYC = 3;

  logic        clk = 1'b0;
  logic        rst, validD, use_rs1D, use_rs2D, regwriteD, regwriteW, branch_takenE;
  logic [4:0]  rs1D, rs2D, RdD, RdW;
  logic        stallF, stallD, flushD, flushE;
  logic [31:0] busy_regs;
  logic [1:0]  state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(
    .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .validD       (validD),
    .rs1D         (rs1D),
    .rs2D         (rs2D),
    .use_rs1D     (use_rs1D),
    .use_rs2D     (use_rs2D),
    .RdD          (RdD),
    .regwriteD    (regwriteD),
    .RdW          (RdW),
    .regwriteW    (regwriteW),
    .branch_takenE(branch_takenE),
    .stallF       (stallF),
    .stallD       (stallD),
    .flushD       (flushD),
    .flushE       (flushE),
    .busy_regs    (busy_regs),
    .state_o      (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  int          n_pass = 0;
  int          n_chk  = 0;
  // Model: outstanding writes per register, remaining flush cycles, stalled last cycle.
  int          mcnt[32];
  int          flush_left = 0;
  bit          in_stall   = 1'b0;
  bit          known      = 1'b0;
  logic [31:0] pc_stall   = '0;
  logic [31:0] pc_flush   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    validD = 0; use_rs1D = 0; use_rs2D = 0; regwriteD = 0; regwriteW = 0;
    branch_takenE = 0; rs1D = 0; rs2D = 0; RdD = 0; RdW = 0;
  endtask

  task automatic rand_inputs();
    int r;
    validD    = ($urandom_range(0, 3) != 0);
    use_rs1D  = ($urandom_range(0, 1) != 0);
    use_rs2D  = ($urandom_range(0, 1) != 0);
    rs1D      = 5'($urandom_range(0, 7));
    rs2D      = 5'($urandom_range(0, 7));
    RdD       = 5'($urandom_range(0, 7));
    regwriteD = ($urandom_range(0, 1) != 0) && (RdD == 0 || mcnt[RdD] < 3);
    r         = $urandom_range(1, 7);
    if (mcnt[r] > 0 && $urandom_range(0, 2) != 0) begin
      regwriteW = 1; RdW = 5'(r);
    end else begin
      regwriteW = ($urandom_range(0, 1) != 0); RdW = 0;
    end
    branch_takenE = ($urandom_range(0, 9) == 0);
  endtask

  // Check the current cycle against the model, advance the model, step the clock.
  task automatic cycle();
    logic        hz, inf, st;
    logic [31:0] bexp;
    hc_state_t   sexp;
    #2;
    inf = (flush_left > 0);
    hz  = validD && ((use_rs1D && rs1D != 0 && mcnt[rs1D] > 0) ||
                     (use_rs2D && rs2D != 0 && mcnt[rs2D] > 0));
    st  = hz && !branch_takenE && !inf;
    if (rst) begin
      chk("rst_stallF", stallF, 0); chk("rst_stallD", stallD, 0);
      chk("rst_flushD", flushD, 0); chk("rst_flushE", flushE, 0);
    end else begin
      chk("flushD", flushD, branch_takenE || inf);
      chk("flushE", flushE, branch_takenE || hz);
      chk("stallD", stallD, st);
      chk("stallF", stallF, st);
    end
    if (known) begin
      bexp = '0;
      for (int i = 1; i < 32; i++) bexp[i] = (mcnt[i] > 0);
      sexp = inf ? HC_FLUSH : (in_stall ? HC_STALL : HC_RUN);
      chk("busy_regs", busy_regs, bexp);
      chk("state", state_o, sexp);
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, pc_stall);
      chk("flush_cnt", flush_cnt, pc_flush);
`endif
    end
    if (rst) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      flush_left = 0; in_stall = 0; pc_stall = '0; pc_flush = '0; known = 1;
    end else begin
      if (validD && regwriteD && RdD != 0 && !hz && !inf && !branch_takenE) mcnt[RdD]++;
      if (regwriteW && RdW != 0) mcnt[RdW]--;
      if (branch_takenE) begin
        flush_left = FLUSH_CYC - 1; in_stall = 0;
      end else if (flush_left > 0) begin
        flush_left--; in_stall = 0;
      end else begin
        in_stall = hz;
      end
      pc_stall += 32'(st);
      pc_flush += 32'(branch_takenE);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    foreach (mcnt[i]) mcnt[i] = 0;
    idle();
    rst = 1;
    repeat (2) begin
      rand_inputs(); cycle();
    end
    rst = 0; idle();
    chk("reset_busy", busy_regs, 0);
    chk("reset_state", state_o, HC_RUN);

    // RAW stall on x5 until its writeback retires.
    validD = 1; regwriteD = 1; RdD = 5; cycle();
    idle(); validD = 1; use_rs1D = 1; rs1D = 5; #1;
    chk("raw_stallF", stallF, 1); chk("raw_stallD", stallD, 1); chk("raw_flushE", flushE, 1);
    cycle(); cycle();
    regwriteW = 1; RdW = 5; #1;
    chk("raw_no_bypass", stallD, 1);
    cycle();
    regwriteW = 0; #1;
    chk("raw_clear", stallD, 0); chk("raw_busy5", busy_regs[5], 0);
    cycle();

    // x0 never busy; unused rs2 never stalls.
    idle(); validD = 1; regwriteD = 1; RdD = 0; cycle();
    chk("x0_busy", busy_regs, 0);
    RdD = 7; cycle();
    idle(); validD = 1; rs2D = 7; use_rs2D = 0; use_rs1D = 1; rs1D = 0; #1;
    chk("rs2_unused", stallD, 0); chk("busy7", busy_regs[7], 1);
    cycle();
    idle(); regwriteW = 1; RdW = 7; cycle();

    // Issue and retire the same register in one cycle.
    idle(); validD = 1; regwriteD = 1; RdD = 3; cycle();
    regwriteW = 1; RdW = 3; cycle();
    chk("same_cycle_busy3", busy_regs[3], 1);
    idle(); regwriteW = 1; RdW = 3; cycle();
    chk("same_cycle_cnt1", busy_regs[3], 0);

    // Branch overrides a pending hazard and suppresses issue.
    idle(); validD = 1; regwriteD = 1; RdD = 9; cycle();
    use_rs1D = 1; rs1D = 9; RdD = 10; branch_takenE = 1; #1;
    chk("br_flushD", flushD, 1); chk("br_flushE", flushE, 1); chk("br_stallD", stallD, 0);
    cycle();
    chk("br_no_issue", busy_regs[10], 0); chk("br_state1", state_o, HC_FLUSH);
    idle(); cycle();
    chk("br_state2", state_o, HC_FLUSH);
    cycle();
    chk("br_state3", state_o, HC_RUN);
    regwriteW = 1; RdW = 9; cycle();

    // Four stall cycles and two branches from a fresh reset.
    idle(); rst = 1; cycle(); rst = 0;
    validD = 1; regwriteD = 1; RdD = 4; cycle();
    idle(); validD = 1; use_rs1D = 1; rs1D = 4;
    repeat (4) cycle();
    idle(); regwriteW = 1; RdW = 4; cycle();
    idle(); branch_takenE = 1; cycle();
    idle(); repeat (3) cycle();
    branch_takenE = 1; cycle();
    idle(); cycle();
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall4", stall_cnt, 4); chk("perf_flush2", flush_cnt, 2);
    rst = 1; cycle(); rst = 0;
    chk("perf_rst_stall", stall_cnt, 0); chk("perf_rst_flush", flush_cnt, 0);
`endif

    // Random traffic with occasional mid-operation reset.
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0; idle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the rv32i 5-stage core.
- Tracks in-flight register writes in a per-register scoreboard, from D->E issue until writeback retire.
- Stalls fetch/decode on read-after-write hazards and flushes decode/execute on taken branches.
- Drives the stall/flush controls of the fetch register and the decode_stage pipeline register. The core has no forwarding, so every RAW hazard resolves by stalling.

Parameters:
- ADW, 5, register address width.
- NREG, 32, number of architectural registers (2**ADW).
- CNTW, 2, width of each scoreboard in-flight counter (covers up to 3 outstanding writes per register).
- FLUSH_CYC, 1, number of cycles decode stays flushed after a taken branch (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- validD  in  1  decode holds a real instruction
- rs1D  in  ADW  source register 1 address in decode
- rs2D  in  ADW  source register 2 address in decode
- use_rs1D  in  1  instruction reads rs1
- use_rs2D  in  1  instruction reads rs2
- RdD  in  ADW  destination register in decode
- regwriteD  in  1  decode instruction writes a register
- RdW  in  ADW  destination register retiring in writeback
- regwriteW  in  1  writeback writes the register file this cycle
- branch_takenE  in  1  taken branch/jump resolved in execute
- stallF  out  1  hold PC/fetch register
- stallD  out  1  hold decode register
- flushD  out  1  clear decode register (bubble)
- flushE  out  1  clear decode->execute register (bubble)
- busy_regs  out  NREG  bit i set when register i has a nonzero in-flight count
- state_o  out  2  current FSM state (hc_state_t)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all scoreboard counters 0, busy_regs 0, state RUN, flush counter 0. stallF, stallD, flushD and flushE are all 0 while rst is high.
- Hazard detection (combinational):
  - hazard = validD && ((use_rs1D && rs1D!=0 && busy[rs1D]) || (use_rs2D && rs2D!=0 && busy[rs2D])).
  - No same-cycle writeback bypass. A hazard clears the cycle after the counter reaches 0, because the register file is written on the clock edge.
- Issue: issue = validD && regwriteD && RdD!=0 && !hazard && state!=FLUSH && !branch_takenE. It increments cnt[RdD] at the clock edge.
- Retire: retire = regwriteW && RdW!=0. It decrements cnt[RdW] at the clock edge.
- Same register issued and retired in one cycle: count unchanged. Different registers: both updates apply.
- Register x0 is never marked busy.
- Counter limits:
  - An issue that would overflow is a design error: assertion fires, count saturates.
  - A retire at 0 is a design error: assertion fires, count stays 0.
- Outputs, with priority branch > flush state > hazard:
  - flushD = branch_takenE || state==FLUSH.
  - flushE = branch_takenE || hazard.
  - stallF = stallD = hazard && !branch_takenE && state!=FLUSH.
- FSM states: RUN, STALL, FLUSH.
  - RUN -> FLUSH on branch_takenE when FLUSH_CYC>1, loading the flush counter with FLUSH_CYC-1. With FLUSH_CYC=1, stay in RUN.
  - RUN -> STALL on hazard.
  - STALL -> RUN when the hazard clears. STALL -> FLUSH (or RUN) on branch_takenE.
  - FLUSH: counter decrements each cycle. At count 1, go to RUN. branch_takenE in FLUSH reloads the counter.
- Reset mid-operation: scoreboard wiped, outputs return to reset values the next cycle. Instructions already in flight are discarded by the pipeline's own reset.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds two outputs:
  - stall_cnt[31:0]: increments each cycle stallD=1.
  - flush_cnt[31:0]: increments once per branch_takenE.
  - Both clear on rst and wrap modulo 2^32.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- rv32i_pkg gains:
  - hc_state_t enum {HC_RUN, HC_STALL, HC_FLUSH} (2 bits).
  - Constant SB_CNTW.
- One sub-module, sb_counter: a single per-register saturating up/down counter with inc, dec and busy, instantiated NREG-1 times by a generate loop (x0 excluded).

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> busy_regs=0, all stall/flush outputs 0, state_o=RUN.
- RAW stall: issue RdD=5 (regwriteD=1), next cycle rs1D=5 with use_rs1D=1 -> stallF=stallD=flushE=1. After regwriteW with RdW=5 retires, the stall drops 1 cycle later and busy_regs[5]=0.
- x0 and unused sources:
  - Issue RdD=0 -> busy_regs stays 0.
  - rs2D=7 busy with use_rs2D=0 -> no stall.
- Simultaneous issue/retire: cnt[3]=1, issue RdD=3 and retire RdW=3 in the same cycle -> busy_regs[3] stays 1 and the count remains 1.
- Branch priority, FLUSH_CYC=3: hazard active when branch_takenE=1 -> flushD=flushE=1, stallD=0, no issue. state_o=FLUSH for 2 cycles, then RUN.
- With HAZARD_PERF_CNT_EN: 4 stall cycles and 2 branches -> stall_cnt=4, flush_cnt=2. Reset mid-count -> both 0.
